// File: rtl/ibuf_row_bank6.sv
// ibuf_row_bank6: six-bank row store for the 6:1 row-select stage; optional overrun counter under IBUF_OVERRUN_CNT_EN
module ibuf_row_bank6 #(
  parameter int DATA_W  = 8,
  parameter int ROW_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic              SYS_CLK,
  input  logic              SYS_NRST,
  input  logic              frame_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        mux_sel,
  input  logic              rd_start,
  input  logic              rd_release,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              mux_6_1_ctrl_update,
  output logic              mux_6_1_ctrl_reset,
  output logic              rd_err,
  output logic [5:0]        bank_full,
  output logic [15:0]       ovr_cnt
);
  localparam int DEPTH = 6 * ROW_LEN;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [2:0] wr_bank, sel;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic rel, wr_fire, wr_last, rd_last, sel_ok, start_ok, load;
  logic [7:0] full_ext;
  logic [5:0] set_mask, clr_mask;
  logic [AW-1:0] wr_addr, rd_addr;
  // Padding to 8 entries lets the illegal select codes 6/7 read as "not full"
  assign full_ext = {2'b00, bank_full};
  assign in_ready = !full_ext[wr_bank];
  assign wr_fire = in_valid && in_ready && !frame_start;
  assign wr_last = wr_cnt == CNT_W'(ROW_LEN - 1);
  assign rd_last = rd_cnt == CNT_W'(ROW_LEN - 1);
  assign sel_ok = (mux_sel <= 3'd5) && full_ext[mux_sel];
  assign start_ok = state == IDLE && rd_start && sel_ok;
  assign load = state == READ && !(out_valid && out_last) && (!out_valid || out_ready);
  assign set_mask = (wr_fire && wr_last) ? 6'b1 << wr_bank : 6'b0;
  assign clr_mask = (state == DONE && rel) ? 6'b1 << sel : 6'b0;
  assign wr_addr = AW'(wr_bank) * AW'(ROW_LEN) + AW'(wr_cnt);
  assign rd_addr = AW'(sel) * AW'(ROW_LEN) + AW'(rd_cnt);
  assign mux_6_1_ctrl_update = state == DONE;
  // Read FSM state register
  always_ff @(posedge SYS_CLK or negedge SYS_NRST)
    if (!SYS_NRST) state <= IDLE;
    else state <= state_n;
  // Read FSM next state; frame_start overrides everything
  always_comb begin
    state_n = state;
    if (frame_start) state_n = IDLE;
    else
      case (state)
        IDLE: state_n = start_ok ? READ : IDLE;
        READ: state_n = (out_valid && out_ready && out_last) ? DONE : READ;
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  // Row storage; contents survive frame_start
  always_ff @(posedge SYS_CLK)
    if (wr_fire) mem[wr_addr] <= in_data;
  // Write pointers, full flags, read datapath and pulses
  always_ff @(posedge SYS_CLK or negedge SYS_NRST)
    if (!SYS_NRST) begin
      wr_bank <= '0;
      wr_cnt <= '0;
      bank_full <= '0;
      rd_cnt <= '0;
      sel <= '0;
      rel <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      mux_6_1_ctrl_reset <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      mux_6_1_ctrl_reset <= frame_start;
      rd_err <= !frame_start && state == IDLE && rd_start && !sel_ok;
      if (frame_start) begin
        wr_bank <= '0;
        wr_cnt <= '0;
        bank_full <= '0;
        rd_cnt <= '0;
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end else begin
        if (wr_fire) begin
          wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
          if (wr_last) wr_bank <= (wr_bank == 3'd5) ? 3'd0 : wr_bank + 3'd1;
        end
        bank_full <= (bank_full | set_mask) & ~clr_mask;
        if (start_ok) begin
          sel <= mux_sel;
          rel <= rd_release;
          rd_cnt <= '0;
        end
        if (load) begin
          out_data <= mem[rd_addr];
          out_last <= rd_last;
          out_valid <= 1'b1;
          rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          out_last <= 1'b0;
        end
      end
    end
`ifdef IBUF_OVERRUN_CNT_EN
  // Saturating count of cycles where the writer was refused
  always_ff @(posedge SYS_CLK or negedge SYS_NRST)
    if (!SYS_NRST) ovr_cnt <= '0;
    else if (frame_start) ovr_cnt <= '0;
    else if (in_valid && !in_ready && ovr_cnt != 16'hFFFF) ovr_cnt <= ovr_cnt + 16'd1;
`else
  assign ovr_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_ibuf_row_bank6.sv
// tb_ibuf_row_bank6: randomized self-checking bench against a bank/row reference model
module tb_ibuf_row_bank6;
  localparam int DATA_W = 8;
  localparam int ROW_LEN = 16;
  logic SYS_CLK = 0, SYS_NRST = 0, frame_start = 0, in_valid = 0;
  logic rd_start = 0, rd_release = 0, out_ready = 0;
  logic [DATA_W-1:0] in_data = '0;
  logic [2:0] mux_sel = '0;
  logic in_ready, out_valid, out_last, mux_6_1_ctrl_update, mux_6_1_ctrl_reset, rd_err;
  logic [DATA_W-1:0] out_data;
  logic [5:0] bank_full;
  logic [15:0] ovr_cnt;

  ibuf_row_bank6 #(.DATA_W(DATA_W), .ROW_LEN(ROW_LEN), .CNT_W(8)) dut (
    .SYS_CLK(SYS_CLK), .SYS_NRST(SYS_NRST), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mux_sel(mux_sel), .rd_start(rd_start), .rd_release(rd_release),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mux_6_1_ctrl_update(mux_6_1_ctrl_update), .mux_6_1_ctrl_reset(mux_6_1_ctrl_reset),
    .rd_err(rd_err), .bank_full(bank_full), .ovr_cnt(ovr_cnt));

  always #5 SYS_CLK = ~SYS_CLK;

  int total = 0, bad = 0;
  logic [DATA_W-1:0] mmem [6][ROW_LEN];
  logic [5:0] mfull = '0;
  int wpos = 0, movr = 0, wr_ready_bad = 0;
  logic [DATA_W-1:0] rx_q[$], first_q[$];
  int upd_n, stall_bad, last_bad, word_bad;
  bit rd_timeout;

  function automatic int exp_ovr();
`ifdef IBUF_OVERRUN_CNT_EN
    return movr;
`else
    return 0;
`endif
  endfunction

  // Drive n write cycles; the model tracks a linear write position over the 6 banks
  task automatic write_cycles(input int n, input int pct, input bit seq);
    wr_ready_bad = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = ($urandom_range(99) < pct);
      in_data = seq ? DATA_W'(wpos) : DATA_W'($urandom);
      if (in_ready !== !mfull[wpos / ROW_LEN]) wr_ready_bad++;
      if (in_valid && !mfull[wpos / ROW_LEN]) begin
        mmem[wpos / ROW_LEN][wpos % ROW_LEN] = in_data;
        if (wpos % ROW_LEN == ROW_LEN - 1) mfull[wpos / ROW_LEN] = 1'b1;
        wpos = (wpos + 1) % (6 * ROW_LEN);
      end else if (in_valid && movr < 65535) movr++;
      @(negedge SYS_CLK);
    end
    in_valid = 0;
  endtask

  // Issue one row read and collect the accepted stream; mode 0 ready, 1 pattern 1,0,0,1, 2 random
  task automatic run_read(input int b, input bit rel, input int mode);
    bit seen = 0, hold = 0;
    int after = 0;
    logic [DATA_W-1:0] prev_d = '0;
    logic prev_l = 0;
    rx_q.delete();
    upd_n = 0; stall_bad = 0; last_bad = 0; word_bad = 0;
    rd_start = 1; mux_sel = 3'(b); rd_release = rel;
    @(negedge SYS_CLK);
    rd_start = 0; rd_release = 0;
    for (int c = 0; c < 400; c++) begin
      if (mux_6_1_ctrl_update === 1'b1) begin upd_n++; seen = 1; end
      if (hold && (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l)) stall_bad++;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(1));
      if (out_valid === 1'b1 && out_ready) begin
        rx_q.push_back(out_data);
        if (out_last !== (rx_q.size() == ROW_LEN)) last_bad++;
      end
      hold = (out_valid === 1'b1) && !out_ready;
      prev_d = out_data; prev_l = out_last;
      @(negedge SYS_CLK);
      if (seen) after++;
      if (after == 3) break;
    end
    out_ready = 0;
    rd_timeout = !seen;
    if (rx_q.size() != ROW_LEN) word_bad++;
    for (int i = 0; i < rx_q.size() && i < ROW_LEN; i++)
      if (rx_q[i] !== mmem[b][i]) word_bad++;
    if (rel) mfull[b] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge SYS_CLK);
    SYS_NRST = 1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL reset out: valid=%b last=%b data=%h want 0", out_valid, out_last, out_data); end
    total++; if (bank_full !== 6'b0) begin bad++; $display("FAIL reset bank_full: got %b want 000000", bank_full); end
    total++; if (mux_6_1_ctrl_update !== 1'b0 || mux_6_1_ctrl_reset !== 1'b0 || rd_err !== 1'b0) begin bad++; $display("FAIL reset pulses: upd=%b rst=%b err=%b want 0", mux_6_1_ctrl_update, mux_6_1_ctrl_reset, rd_err); end
    total++; if (ovr_cnt !== 16'd0) begin bad++; $display("FAIL reset ovr_cnt: got %0d want 0", ovr_cnt); end
  endtask

  task automatic test_fill();
    write_cycles(6 * ROW_LEN + 1, 100, 1);
    total++; if (wr_ready_bad != 0) begin bad++; $display("FAIL fill in_ready: got %0d mismatched cycles want 0", wr_ready_bad); end
    total++; if (bank_full !== 6'b111111) begin bad++; $display("FAIL fill bank_full: got %b want 111111", bank_full); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill stall: in_ready got %b want 0", in_ready); end
    total++; if (int'(ovr_cnt) != exp_ovr()) begin bad++; $display("FAIL fill ovr_cnt: got %0d want %0d", ovr_cnt, exp_ovr()); end
  endtask

  task automatic test_overrun();
    write_cycles(10, 100, 0);
    total++; if (wr_ready_bad != 0) begin bad++; $display("FAIL overrun in_ready: got %0d mismatched cycles want 0", wr_ready_bad); end
    total++; if (int'(ovr_cnt) != exp_ovr()) begin bad++; $display("FAIL overrun ovr_cnt: got %0d want %0d", ovr_cnt, exp_ovr()); end
  endtask

  task automatic test_read_release();
    run_read(3, 1, 0);
    total++; if (rd_timeout) begin bad++; $display("FAIL release timeout: no update pulse within budget"); end
    total++; if (word_bad != 0) begin bad++; $display("FAIL release words: got %0d bad of %0d words want 0", word_bad, rx_q.size()); end
    total++; if (rx_q.size() > 0 && rx_q[0] !== 8'd48) begin bad++; $display("FAIL release first word: got %0d want 48", rx_q[0]); end
    total++; if (last_bad != 0) begin bad++; $display("FAIL release out_last: got %0d misplaced want 0", last_bad); end
    total++; if (upd_n != 1) begin bad++; $display("FAIL release update: got %0d pulses want 1", upd_n); end
    total++; if (bank_full !== mfull) begin bad++; $display("FAIL release bank_full: got %b want %b", bank_full, mfull); end
    total++; if (in_ready !== !mfull[wpos / ROW_LEN]) begin bad++; $display("FAIL release in_ready: got %b want %b", in_ready, !mfull[wpos / ROW_LEN]); end
  endtask

  task automatic test_reread();
    run_read(1, 0, 0);
    first_q = rx_q;
    total++; if (word_bad != 0 || upd_n != 1) begin bad++; $display("FAIL reread first: bad words %0d updates %0d want 0 and 1", word_bad, upd_n); end
    run_read(1, 0, 0);
    total++; if (word_bad != 0 || upd_n != 1) begin bad++; $display("FAIL reread second: bad words %0d updates %0d want 0 and 1", word_bad, upd_n); end
    total++; if (rx_q != first_q) begin bad++; $display("FAIL reread identical: got sizes %0d/%0d or differing data", first_q.size(), rx_q.size()); end
    total++; if (bank_full[1] !== 1'b1) begin bad++; $display("FAIL reread bank_full[1]: got %b want 1", bank_full[1]); end
  endtask

  task automatic test_backpressure();
    run_read(2, 0, 1);
    total++; if (rd_timeout) begin bad++; $display("FAIL backpressure timeout: no update pulse within budget"); end
    total++; if (word_bad != 0) begin bad++; $display("FAIL backpressure words: got %0d bad of %0d words want 0", word_bad, rx_q.size()); end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL backpressure stall: got %0d unstable cycles want 0", stall_bad); end
    total++; if (last_bad != 0 || upd_n != 1) begin bad++; $display("FAIL backpressure last/update: last_bad %0d updates %0d want 0 and 1", last_bad, upd_n); end
  endtask

  task automatic test_errors();
    int seen_v = 0;
    for (int k = 6; k < 8; k++) begin
      rd_start = 1; mux_sel = 3'(k);
      @(negedge SYS_CLK);
      rd_start = 0; mux_sel = 0;
      total++; if (rd_err !== 1'b1) begin bad++; $display("FAIL err sel%0d: rd_err got %b want 1", k, rd_err); end
      @(negedge SYS_CLK);
      total++; if (rd_err !== 1'b0) begin bad++; $display("FAIL err sel%0d pulse width: rd_err got %b want 0", k, rd_err); end
    end
    rd_start = 1; mux_sel = 3'd3;
    @(negedge SYS_CLK);
    rd_start = 0; mux_sel = 0;
    total++; if (rd_err !== !mfull[3]) begin bad++; $display("FAIL err empty bank: rd_err got %b want %b", rd_err, !mfull[3]); end
    repeat (4) begin
      if (out_valid === 1'b1 || mux_6_1_ctrl_update === 1'b1) seen_v++;
      @(negedge SYS_CLK);
    end
    total++; if (seen_v != 0) begin bad++; $display("FAIL err stays idle: got %0d active cycles want 0", seen_v); end
  endtask

  task automatic test_frame_start();
    int acc = 0, upd = 0;
    bit fired = 0;
    rd_start = 1; mux_sel = 3'd0; rd_release = 0;
    @(negedge SYS_CLK);
    rd_start = 0;
    out_ready = 1;
    for (int c = 0; c < 50; c++) begin
      if (mux_6_1_ctrl_update === 1'b1) upd++;
      if (acc == 5) begin frame_start = 1; fired = 1; break; end
      if (out_valid === 1'b1) acc++;
      @(negedge SYS_CLK);
    end
    @(negedge SYS_CLK);
    frame_start = 0;
    out_ready = 0;
    mfull = '0; wpos = 0; movr = 0;
    total++; if (!fired) begin bad++; $display("FAIL frame timeout: got %0d words want 5", acc); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL frame out_valid: got %b want 0", out_valid); end
    total++; if (mux_6_1_ctrl_reset !== 1'b1) begin bad++; $display("FAIL frame ctrl_reset: got %b want 1", mux_6_1_ctrl_reset); end
    total++; if (bank_full !== 6'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL frame clear: bank_full %b in_ready %b want 000000 and 1", bank_full, in_ready); end
    total++; if (ovr_cnt !== 16'd0) begin bad++; $display("FAIL frame ovr_cnt: got %0d want 0", ovr_cnt); end
    repeat (4) begin
      if (mux_6_1_ctrl_update === 1'b1) upd++;
      @(negedge SYS_CLK);
    end
    total++; if (upd != 0) begin bad++; $display("FAIL frame update: got %0d pulses want 0", upd); end
    total++; if (mux_6_1_ctrl_reset !== 1'b0) begin bad++; $display("FAIL frame ctrl_reset width: got %b want 0", mux_6_1_ctrl_reset); end
  endtask

  task automatic test_random();
    int b;
    write_cycles(200, 70, 0);
    total++; if (wr_ready_bad != 0 || bank_full !== mfull) begin bad++; $display("FAIL random refill: ready mismatches %0d bank_full %b want 0 and %b", wr_ready_bad, bank_full, mfull); end
    for (int k = 0; k < 8; k++) begin
      if (mfull == 6'b0) write_cycles(60, 90, 0);
      if (mfull == 6'b0) continue;
      do b = $urandom_range(5); while (!mfull[b]);
      run_read(b, 1'($urandom_range(1)), 2);
      total++; if (rd_timeout || word_bad != 0 || upd_n != 1) begin bad++; $display("FAIL random read %0d bank %0d: timeout %0d bad words %0d updates %0d want 0 0 1", k, b, rd_timeout, word_bad, upd_n); end
      total++; if (stall_bad != 0 || last_bad != 0) begin bad++; $display("FAIL random stall %0d: unstable %0d last_bad %0d want 0", k, stall_bad, last_bad); end
      total++; if (bank_full !== mfull) begin bad++; $display("FAIL random bank_full %0d: got %b want %b", k, bank_full, mfull); end
      write_cycles(40, 60, 0);
      total++; if (wr_ready_bad != 0 || bank_full !== mfull) begin bad++; $display("FAIL random write %0d: ready mismatches %0d bank_full %b want 0 and %b", k, wr_ready_bad, bank_full, mfull); end
      total++; if (int'(ovr_cnt) != exp_ovr()) begin bad++; $display("FAIL random ovr_cnt %0d: got %0d want %0d", k, ovr_cnt, exp_ovr()); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_overrun();
    test_read_release();
    test_reread();
    test_backpressure();
    test_errors();
    test_frame_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
